// File: rtl/write_responder.sv
// write_responder: memory-side end of the solver write port. Captures arbitrator writes
// with a write_en/ack handshake, buffers them, and drains them in order to an Avalon-MM master.
module write_responder #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [DATA_W-1:0]             in_data,
  input  logic [ADDR_W-1:0]             in_addr,
  input  logic                          in_write_en,
  output logic                          in_ack,
  output logic [ADDR_W-1:0]             out_address,
  output logic [DATA_W-1:0]             out_writedata,
  output logic [DATA_W/8-1:0]           out_byteenable,
  output logic                          out_write,
  input  logic                          out_waitrequest,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          idle
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

  logic [ADDR_W-1:0] addr_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] data_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push;
  logic              pop;
  logic              advance;

  // The ack cycle blocks a second capture of the request the arbitrator is still holding,
  // and fullness ignores a same-edge pop so acceptance never depends on the master side.
  assign push    = in_write_en && !in_ack && (fifo_count < FULL_COUNT);
  assign advance = !out_write || !out_waitrequest;
  assign pop     = advance && (fifo_count != '0);

  assign out_byteenable = {(DATA_W/8){out_write}};
  assign idle           = (fifo_count == '0) && !out_write && !in_ack;

  always_ff @(posedge clock) begin
    if (push) begin
      addr_mem[wr_ptr] <= in_addr;
      data_mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      in_ack     <= 1'b0;
    end else begin
      in_ack <= push;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        fifo_count <= fifo_count + 1'b1;
      end else if (pop && !push) begin
        fifo_count <= fifo_count - 1'b1;
      end
    end
  end

  // Output register holds its transfer stable while the slave stalls.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_write     <= 1'b0;
      out_address   <= '0;
      out_writedata <= '0;
    end else if (advance) begin
      out_write <= pop;
      if (pop) begin
        out_address   <= addr_mem[rd_ptr];
        out_writedata <= data_mem[rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_write_responder.sv
// tb_write_responder: table vectors, hand-written corner sequences and randomized traffic
// checked against a queue-based reference model of the write responder.
module tb_write_responder;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] a;
    logic [15:0] d;
  } wr_t;

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [15:0] data;
    logic        wait_req;
    logic        exp_ack;
    logic        exp_write;
    logic [31:0] exp_addr;
    logic [15:0] exp_data;
    logic [2:0]  exp_count;
    logic        exp_idle;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] in_data;
  logic [31:0] in_addr;
  logic        in_write_en;
  logic        in_ack;
  logic [31:0] out_address;
  logic [15:0] out_writedata;
  logic [1:0]  out_byteenable;
  logic        out_write;
  logic        out_waitrequest;
  logic [2:0]  fifo_count;
  logic        idle;

  int checks = 0;
  int errors = 0;
  bit model_on = 1'b0;

  int          req_idx = 0;
  int          req_total = 0;
  logic [15:0] req_dbase = '0;
  logic [31:0] req_abase = '0;
  int          cyc;

  wr_t  seen_q[$];
  wr_t  m_q[$];
  bit   m_ack = 1'b0;
  bit   m_out_valid = 1'b0;
  wr_t  m_out = '0;
  int   m_before;
  bit   m_take;
  bit   m_adv;
  vec_t vecs[6];

  write_responder #(.FIFO_DEPTH(DEPTH), .ADDR_W(32), .DATA_W(16)) dut (
    .clock(clock),
    .reset(reset),
    .in_data(in_data),
    .in_addr(in_addr),
    .in_write_en(in_write_en),
    .in_ack(in_ack),
    .out_address(out_address),
    .out_writedata(out_writedata),
    .out_byteenable(out_byteenable),
    .out_write(out_write),
    .out_waitrequest(out_waitrequest),
    .fifo_count(fifo_count),
    .idle(idle)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: a queue of accepted writes plus one output slot, stepped once per edge.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_q.delete();
      m_ack       = 1'b0;
      m_out_valid = 1'b0;
      m_out       = '0;
    end else begin
      m_before = m_q.size();
      m_take   = in_write_en && !m_ack && (m_before < DEPTH);
      m_adv    = !m_out_valid || !out_waitrequest;
      if (m_adv) begin
        if (m_before > 0) begin
          m_out       = m_q.pop_front();
          m_out_valid = 1'b1;
        end else begin
          m_out_valid = 1'b0;
        end
      end
      if (m_take) m_q.push_back({in_addr, in_data});
      m_ack = m_take;
    end
  end

  always @(negedge clock) begin
    if (model_on && reset) begin
      check("model ack", in_ack, m_ack);
      check("model write", out_write, m_out_valid);
      check("model count", fifo_count, m_q.size());
      check("model idle", idle, (m_q.size() == 0) && !m_out_valid && !m_ack);
      check("model byteenable", out_byteenable, m_out_valid ? 2'b11 : 2'b00);
      if (m_out_valid) check("model payload", {out_address, out_writedata}, m_out);
    end
  end

  always @(negedge clock) begin
    if (reset && out_write && !out_waitrequest) seen_q.push_back({out_address, out_writedata});
  end

  // Requester behaves like the arbitrator: holds each write until it sees in_ack.
  task automatic tick();
    if (req_idx < req_total) begin
      in_write_en = 1'b1;
      in_addr     = req_abase + 32'(req_idx * 4);
      in_data     = req_dbase + 16'(req_idx);
    end else begin
      in_write_en = 1'b0;
      in_addr     = 'x;
      in_data     = 'x;
    end
    @(posedge clock);
    #1;
    if (in_ack) req_idx++;
  endtask

  task automatic run_table(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      in_write_en     = vecs[i].wen;
      in_addr         = vecs[i].addr;
      in_data         = vecs[i].data;
      out_waitrequest = vecs[i].wait_req;
      @(posedge clock);
      #1;
      check($sformatf("vec%0d ack", i), in_ack, vecs[i].exp_ack);
      check($sformatf("vec%0d write", i), out_write, vecs[i].exp_write);
      check($sformatf("vec%0d count", i), fifo_count, vecs[i].exp_count);
      check($sformatf("vec%0d idle", i), idle, vecs[i].exp_idle);
      check($sformatf("vec%0d byteenable", i), out_byteenable, vecs[i].exp_write ? 2'b11 : 2'b00);
      if (vecs[i].exp_write) begin
        check($sformatf("vec%0d addr", i), out_address, vecs[i].exp_addr);
        check($sformatf("vec%0d data", i), out_writedata, vecs[i].exp_data);
      end
    end
  endtask

  task automatic check_seen(input string name, input int n, input logic [15:0] dbase,
                            input logic [31:0] abase);
    check({name, " transfer count"}, seen_q.size(), n);
    for (int i = 0; i < seen_q.size() && i < n; i++) begin
      check($sformatf("%s data[%0d]", name, i), seen_q[i].d, dbase + 16'(i));
      check($sformatf("%s addr[%0d]", name, i), seen_q[i].a, abase + 32'(i * 4));
    end
  endtask

  task automatic drain(input string name, input int limit);
    cyc = 0;
    while ((req_idx < req_total || !idle) && cyc < limit) begin
      tick();
      cyc++;
    end
    check({name, " drain within bound"}, cyc < limit, 1'b1);
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'h100, 16'hBEEF, 1'b0, 1'b1, 1'b0, 32'h0,   16'h0,    3'd1, 1'b0};
    vecs[1] = '{1'b0, 32'hx,   16'hx,    1'b0, 1'b0, 1'b1, 32'h100, 16'hBEEF, 3'd0, 1'b0};
    vecs[2] = '{1'b0, 32'hx,   16'hx,    1'b0, 1'b0, 1'b0, 32'h0,   16'h0,    3'd0, 1'b1};
    vecs[3] = '{1'b1, 32'h200, 16'hCAFE, 1'b0, 1'b1, 1'b0, 32'h0,   16'h0,    3'd1, 1'b0};
    vecs[4] = '{1'b1, 32'h200, 16'hCAFE, 1'b0, 1'b0, 1'b1, 32'h200, 16'hCAFE, 3'd0, 1'b0};
    vecs[5] = '{1'b0, 32'hx,   16'hx,    1'b0, 1'b0, 1'b0, 32'h0,   16'h0,    3'd0, 1'b1};

    in_write_en     = 1'b0;
    in_addr         = '0;
    in_data         = '0;
    out_waitrequest = 1'b0;

    #3;
    check("reset ack", in_ack, 1'b0);
    check("reset write", out_write, 1'b0);
    check("reset byteenable", out_byteenable, 2'b00);
    check("reset addr", out_address, 32'h0);
    check("reset data", out_writedata, 16'h0);
    check("reset count", fifo_count, 3'd0);
    check("reset idle", idle, 1'b1);
    #9;
    reset    = 1'b1;
    model_on = 1'b1;
    @(posedge clock);
    #1;

    $display("[TB] single write and held write_en");
    seen_q.delete();
    run_table(0, 2);
    check("single transfer count", seen_q.size(), 1);
    seen_q.delete();
    run_table(3, 5);
    check("held write_en transfer count", seen_q.size(), 1);

    $display("[TB] stall with six writes");
    seen_q.delete();
    req_idx = 0; req_total = 6; req_dbase = 16'h0001; req_abase = 32'h2000;
    out_waitrequest = 1'b1;
    repeat (10) tick();
    check("stall acks", req_idx, 5);
    check("stall count full", fifo_count, 3'd4);
    check("stall output held", {out_write, out_writedata}, {1'b1, 16'h0001});
    out_waitrequest = 1'b0;
    drain("stall", 60);
    check_seen("stall", 6, 16'h0001, 32'h2000);

    $display("[TB] wrap-around with toggling waitrequest");
    seen_q.delete();
    req_idx = 0; req_total = 20; req_dbase = 16'h0000; req_abase = 32'h4000;
    cyc = 0;
    while ((req_idx < req_total || !idle) && cyc < 200) begin
      out_waitrequest = cyc[0];
      tick();
      cyc++;
    end
    check("wrap within bound", cyc < 200, 1'b1);
    check_seen("wrap", 20, 16'h0000, 32'h4000);
    check("wrap count empty", fifo_count, 3'd0);
    check("wrap idle", idle, 1'b1);

    $display("[TB] push and pop on the same edge");
    seen_q.delete();
    out_waitrequest = 1'b1;
    req_idx = 0; req_total = 3; req_dbase = 16'h00A1; req_abase = 32'h6000;
    repeat (6) tick();
    check("pp setup count", fifo_count, 3'd2);
    check("pp setup ack", in_ack, 1'b0);
    check("pp setup head", out_writedata, 16'h00A1);
    req_total = 4;
    out_waitrequest = 1'b0;
    tick();
    check("pp count unchanged", fifo_count, 3'd2);
    check("pp ack", in_ack, 1'b1);
    check("pp head advanced", out_writedata, 16'h00A2);
    tick();
    check("pp next head", out_writedata, 16'h00A3);
    check("pp next count", fifo_count, 3'd1);
    drain("pp", 30);
    check_seen("pp", 4, 16'h00A1, 32'h6000);

    $display("[TB] reset mid-burst");
    seen_q.delete();
    out_waitrequest = 1'b1;
    req_idx = 0; req_total = 4; req_dbase = 16'h00B0; req_abase = 32'h8000;
    repeat (7) tick();
    check("burst count", fifo_count, 3'd3);
    check("burst write", out_write, 1'b1);
    in_write_en = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("async ack", in_ack, 1'b0);
    check("async write", out_write, 1'b0);
    check("async byteenable", out_byteenable, 2'b00);
    check("async addr", out_address, 32'h0);
    check("async data", out_writedata, 16'h0);
    check("async count", fifo_count, 3'd0);
    check("async idle", idle, 1'b1);
    @(posedge clock);
    #3;
    reset = 1'b1;
    req_idx = 0; req_total = 0;
    out_waitrequest = 1'b0;
    repeat (3) tick();
    check("no stale transfer", seen_q.size(), 0);
    check("post reset idle", idle, 1'b1);
    run_table(0, 2);

    $display("[TB] randomized traffic");
    seen_q.delete();
    req_idx = 0; req_total = 0;
    req_dbase = 16'($urandom);
    req_abase = $urandom & 32'hFFFF_FF00;
    for (int c = 0; c < 400; c++) begin
      if (req_idx == req_total && $urandom_range(0, 3) != 0) req_total++;
      out_waitrequest = ($urandom_range(0, 2) == 0);
      tick();
    end
    out_waitrequest = 1'b0;
    drain("random", 60);
    check_seen("random", req_total, req_dbase, req_abase);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
